ysyx_23060077_riscv_ifu_fetch: RTL and testbench

Parametrised instruction fetch unit for the ysyx_23060077 RISC-V core. It replaces the combinational DPI memory read with a registered, handshaked fetch path. A sequential PC generator issues AXI4-Lite-style read requests to the instruction bus and buffers returned instructions in a small FIFO. The FIFO feeds the IDU over a valid/ready interface. Branch/jump redirects flush the buffer and discard any in-flight response. Sits between the pipeline control (redirect source) and the IDU, in front of the instruction memory/bus arbiter.

---
 rtl/ysyx_23060077_riscv_ifu_fetch.sv | 149 ++++++++++++++
 tb/tb_ysyx_23060077_riscv_ifu_fetch.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060077_riscv_ifu_fetch.sv
// Registered, handshaked instruction fetch with a small instruction FIFO.
// Optional access-fault tracking: YSYX_23060077_IFU_ACCESS_FAULT_EN.
module ysyx_23060077_riscv_ifu_fetch #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           INST_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic                  out_fault,
    output logic [DATA_WIDTH-1:0] ifu_araddr,
    output logic                  ifu_arvalid,
    input  logic                  ifu_arready,
    input  logic [INST_WIDTH-1:0] ifu_rdata,
    input  logic [1:0]            ifu_rresp,
    input  logic                  ifu_rvalid,
    output logic                  ifu_rready
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  drop_q, drop_d;
    logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]         count_q;
    logic [DATA_WIDTH-1:0] pc_mem_q   [FIFO_DEPTH];
    logic [INST_WIDTH-1:0] inst_mem_q [FIFO_DEPTH];
    logic                  ar_hs, r_hs, push, pop;

    assign ifu_arvalid = (state_q == S_REQ);
    assign ifu_rready  = (state_q == S_WAIT);
    assign ifu_araddr  = req_pc_q;
    assign ar_hs       = ifu_arvalid & ifu_arready;
    assign r_hs        = ifu_rvalid & ifu_rready;

    assign out_valid = (count_q != '0) & ~redirect_valid;
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign out_inst  = inst_mem_q[rd_ptr_q];
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        drop_d     = drop_q;
        push       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!redirect_valid && count_q < CW'(FIFO_DEPTH)) begin
                    state_d  = S_REQ;
                    req_pc_d = fetch_pc_q;
                end
            end
            S_REQ: begin
                if (ar_hs) begin
                    state_d = S_WAIT;
                    // a doomed request must not advance the redirected PC
                    if (!drop_q) fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
                end
            end
            S_WAIT: begin
                if (r_hs) begin
                    state_d = S_IDLE;
                    push    = ~drop_q & ~redirect_valid;
                    drop_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~DATA_WIDTH'(3);
            if (state_q == S_REQ || (state_q == S_WAIT && !r_hs)) drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                pc_mem_q[wr_ptr_q]   <= req_pc_q;
                inst_mem_q[wr_ptr_q] <= ifu_rdata;
                wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop) count_q <= count_q + CW'(1);
            else if (!push && pop) count_q <= count_q - CW'(1);
        end
    end

`ifdef YSYX_23060077_IFU_ACCESS_FAULT_EN
    logic fault_mem_q [FIFO_DEPTH];

    assign out_fault = fault_mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fault_mem_q[i] <= 1'b0;
        end else if (push) begin
            fault_mem_q[wr_ptr_q] <= (ifu_rresp != 2'b00);
        end
    end
`else
    logic unused_rresp;

    assign unused_rresp = ^ifu_rresp;
    assign out_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060077_riscv_ifu_fetch.sv
// Random and directed checks of the IFU against an in-order fetch-stream model.
// The bus is modelled as an address-indexed memory with random latencies.
module tb_ysyx_23060077_riscv_ifu_fetch;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef logic [31:0] q32_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid, out_valid, out_ready, out_fault;
    logic [31:0] redirect_pc, out_pc, out_inst;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [1:0]  ifu_rresp;

    always #5 clk = ~clk;

    ysyx_23060077_riscv_ifu_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_fault(out_fault),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
        .ifu_arready(ifu_arready), .ifu_rdata(ifu_rdata),
        .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid),
        .ifu_rready(ifu_rready)
    );

    int n_chk = 0, n_err = 0, total_pops = 0;
    int ar_pct, r_pct, rdy_pct, mem_mode;
    bit rand_fault, prev_stall;
    logic [31:0] fault_pc, exp_pc, prev_addr;
    q32_t pend, ar_log, pop_log, flt_log;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qget(input q32_t q, input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (mem_mode == 0) return 32'h0000_0013;
        return (a ^ 32'h1357_9bdf) + {a[15:0], a[31:16]};
    endfunction

    function automatic logic [1:0] resp_f(input logic [31:0] a);
        if (rand_fault) return (a[5:2] == 4'h3) ? 2'b11 : 2'b00;
        return (a == fault_pc) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic exp_flt(input logic [31:0] a);
`ifdef YSYX_23060077_IFU_ACCESS_FAULT_EN
        return resp_f(a) != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        ifu_arready = 1'b0;
        ifu_rvalid = 1'b0;
        ifu_rdata = '0;
        ifu_rresp = '0;
        out_ready = 1'b0;
        #1;
        pend.delete();
        ar_log.delete();
        pop_log.delete();
        flt_log.delete();
        exp_pc = RST_PC;
        prev_stall = 1'b0;
        check("rst_arvalid", 32'(ifu_arvalid), 0);
        check("rst_rready", 32'(ifu_rready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_inst", out_inst, 0);
        check("rst_out_fault", 32'(out_fault), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("first_cycle_arvalid", 32'(ifu_arvalid), 0);
    endtask

    // One cycle: drive at negedge, then model what the next rising edge does.
    task automatic cyc(input bit rv, input logic [31:0] rpc);
        @(negedge clk);
        ifu_arready = ($urandom_range(99) < ar_pct);
        ifu_rvalid = (pend.size() != 0) && ($urandom_range(99) < r_pct);
        if (pend.size() != 0) begin
            ifu_rdata = mem_f(pend[0]);
            ifu_rresp = resp_f(pend[0]);
        end else begin
            ifu_rdata = $urandom;
            ifu_rresp = 2'($urandom);
        end
        out_ready = ($urandom_range(99) < rdy_pct);
        redirect_valid = rv;
        redirect_pc = rpc;
        #1;
        if (prev_stall) begin
            check("ar_hold_valid", 32'(ifu_arvalid), 1);
            check("ar_hold_addr", ifu_araddr, prev_addr);
        end
        if (rv) check("redirect_kills_valid", 32'(out_valid), 0);
        if (out_valid && out_ready) begin
            check("out_pc", out_pc, exp_pc);
            check("out_inst", out_inst, mem_f(exp_pc));
            check("out_fault", 32'(out_fault), 32'(exp_flt(exp_pc)));
            pop_log.push_back(out_pc);
            flt_log.push_back(32'(out_fault));
            total_pops++;
            exp_pc += 32'd4;
        end
        if (rv) exp_pc = rpc & ~32'd3;
        if (ifu_arvalid && ifu_arready) begin
            check("one_outstanding", pend.size(), 0);
            pend.push_back(ifu_araddr);
            ar_log.push_back(ifu_araddr);
        end
        if (ifu_rvalid && ifu_rready) void'(pend.pop_front());
        prev_stall = ifu_arvalid && !ifu_arready;
        prev_addr = ifu_araddr;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0);
    endtask

    function automatic logic [31:0] rnd_pc();
        if ($urandom_range(3) == 0) return 32'hFFFF_FFF0 + $urandom_range(15);
        return 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
    endfunction

    initial begin
        ar_pct = 100; r_pct = 100; rdy_pct = 100;
        mem_mode = 0; rand_fault = 0; fault_pc = 32'h1;

        do_reset();
        run(1);
        check("first_arvalid", 32'(ifu_arvalid), 1);
        check("first_araddr", ifu_araddr, RST_PC);
        run(11);
        check("zw_pop_count", pop_log.size(), 4);
        check("zw_pc0", qget(pop_log, 0), 32'h8000_0000);
        check("zw_pc1", qget(pop_log, 1), 32'h8000_0004);
        check("zw_pc2", qget(pop_log, 2), 32'h8000_0008);

        do_reset();
        rdy_pct = 0;
        run(30);
        check("stall_reads", ar_log.size(), 2);
        check("stall_arvalid", 32'(ifu_arvalid), 0);
        rdy_pct = 100;
        run(1);
        rdy_pct = 0;
        run(20);
        check("stall_one_more", ar_log.size(), 3);
        check("stall_one_pop", pop_log.size(), 1);

        do_reset();
        rdy_pct = 100; r_pct = 0;
        run(2);
        cyc(1'b1, 32'h8000_0103);
        r_pct = 100;
        run(15);
        check("rdw_araddr", qget(ar_log, 1), 32'h8000_0100);
        check("rdw_first_pc", qget(pop_log, 0), 32'h8000_0100);

        do_reset();
        ar_pct = 0;
        run(5);
        check("rdq_held_addr", ifu_araddr, RST_PC);
        cyc(1'b1, 32'h8000_0200);
        ar_pct = 100;
        run(15);
        check("rdq_ar0", qget(ar_log, 0), 32'h8000_0000);
        check("rdq_ar1", qget(ar_log, 1), 32'h8000_0200);
        check("rdq_first_pc", qget(pop_log, 0), 32'h8000_0200);

        do_reset();
        cyc(1'b1, 32'hFFFF_FFF8);
        run(15);
        check("wrap_ar2", qget(ar_log, 2), 32'hFFFF_FFFC);
        check("wrap_ar3", qget(ar_log, 3), 32'h0000_0000);
        check("wrap_pop2", qget(pop_log, 2), 32'h0000_0000);

        do_reset();
        fault_pc = 32'h8000_0004;
        run(12);
        check("flt_e0", qget(flt_log, 0), 0);
        check("flt_e1", qget(flt_log, 1), 32'(exp_flt(32'h8000_0004)));
        check("flt_e2", qget(flt_log, 2), 0);

        mem_mode = 1; rand_fault = 1; fault_pc = 32'h1;
        total_pops = 0;
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            if (i % 250 == 0) begin
                ar_pct = $urandom_range(100, 20);
                r_pct = $urandom_range(100, 20);
                rdy_pct = $urandom_range(100, 10);
            end
            if (i == 1200) do_reset();
            if ($urandom_range(19) == 0) cyc(1'b1, rnd_pc());
            else cyc(1'b0, '0);
        end
        ar_pct = 100; r_pct = 100; rdy_pct = 100;
        run(30);
        check("rand_progress", 32'(total_pops > 50), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
